// File: rtl/sam_kbd_pkg.sv
// Shared definitions for the SAM keyboard matrix decoder: PS/2 set-2
// scancode constants, prefix FSM states and the fixed SAM 9x8 keymap.
package sam_kbd_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_REL     = 8'hF0;
  localparam logic [7:0] SC_PAUSE   = 8'hE1;

  // Fake shifts emitted after E0 by some keyboards
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;

  // Modifier and hotkey codes
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_ALT     = 8'h11;
  localparam logic [7:0] SC_DEL     = 8'h71;
  localparam logic [7:0] SC_BKSP    = 8'h66;
  localparam logic [7:0] SC_F11     = 8'h78;

  // Bytes still to swallow after E1 (the Pause make/break sequence)
  localparam logic [3:0] PAUSE_SKIP = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_REL     = 3'd2,
    ST_EXT_REL = 3'd3,
    ST_PAUSE   = 3'd4
  } kbd_state_e;

  // Controller/status bytes that never carry a key event
  function automatic logic is_ignored(input logic [7:0] code);
    logic res;
    case (code)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: res = 1'b1;
      default:                                  res = 1'b0;
    endcase
    return res;
  endfunction

  // Pack a matrix position as {hit, row, col}
  function automatic logic [7:0] km(input logic [3:0] row, input logic [2:0] col);
    return {1'b1, row, col};
  endfunction

  // {ext, code} -> {hit, row[3:0], col[2:0]}; hit=0 for unmapped keys
  function automatic logic [7:0] sam_keymap(input logic ext, input logic [7:0] code);
    logic [7:0] m;
    case ({ext, code})
      // row 0: CS Z X C V F1 F2 F3 (both shifts are CS)
      9'h012, 9'h059: m = km(4'd0, 3'd0);
      9'h01A: m = km(4'd0, 3'd1);
      9'h022: m = km(4'd0, 3'd2);
      9'h021: m = km(4'd0, 3'd3);
      9'h02A: m = km(4'd0, 3'd4);
      9'h005: m = km(4'd0, 3'd5);
      9'h006: m = km(4'd0, 3'd6);
      9'h004: m = km(4'd0, 3'd7);
      // row 1: A S D F G F4 F5 F6
      9'h01C: m = km(4'd1, 3'd0);
      9'h01B: m = km(4'd1, 3'd1);
      9'h023: m = km(4'd1, 3'd2);
      9'h02B: m = km(4'd1, 3'd3);
      9'h034: m = km(4'd1, 3'd4);
      9'h00C: m = km(4'd1, 3'd5);
      9'h003: m = km(4'd1, 3'd6);
      9'h00B: m = km(4'd1, 3'd7);
      // row 2: Q W E R T F7 F8 F9
      9'h015: m = km(4'd2, 3'd0);
      9'h01D: m = km(4'd2, 3'd1);
      9'h024: m = km(4'd2, 3'd2);
      9'h02D: m = km(4'd2, 3'd3);
      9'h02C: m = km(4'd2, 3'd4);
      9'h083: m = km(4'd2, 3'd5);
      9'h00A: m = km(4'd2, 3'd6);
      9'h001: m = km(4'd2, 3'd7);
      // row 3: 1 2 3 4 5 ESC TAB CAPS
      9'h016: m = km(4'd3, 3'd0);
      9'h01E: m = km(4'd3, 3'd1);
      9'h026: m = km(4'd3, 3'd2);
      9'h025: m = km(4'd3, 3'd3);
      9'h02E: m = km(4'd3, 3'd4);
      9'h076: m = km(4'd3, 3'd5);
      9'h00D: m = km(4'd3, 3'd6);
      9'h058: m = km(4'd3, 3'd7);
      // row 4: 0 9 8 7 6 - + DELETE (keypad 8 and keypad + both give +)
      9'h045: m = km(4'd4, 3'd0);
      9'h046: m = km(4'd4, 3'd1);
      9'h03E: m = km(4'd4, 3'd2);
      9'h03D: m = km(4'd4, 3'd3);
      9'h036: m = km(4'd4, 3'd4);
      9'h04E: m = km(4'd4, 3'd5);
      9'h075, 9'h079: m = km(4'd4, 3'd6);
      9'h066, 9'h171: m = km(4'd4, 3'd7);
      // row 5: P O I U Y = " F0
      9'h04D: m = km(4'd5, 3'd0);
      9'h044: m = km(4'd5, 3'd1);
      9'h043: m = km(4'd5, 3'd2);
      9'h03C: m = km(4'd5, 3'd3);
      9'h035: m = km(4'd5, 3'd4);
      9'h055: m = km(4'd5, 3'd5);
      9'h052: m = km(4'd5, 3'd6);
      9'h009: m = km(4'd5, 3'd7);
      // row 6: ENTER L K J H ; : EDIT (right Alt)
      9'h05A: m = km(4'd6, 3'd0);
      9'h04B: m = km(4'd6, 3'd1);
      9'h042: m = km(4'd6, 3'd2);
      9'h03B: m = km(4'd6, 3'd3);
      9'h033: m = km(4'd6, 3'd4);
      9'h04C: m = km(4'd6, 3'd5);
      9'h054: m = km(4'd6, 3'd6);
      9'h111: m = km(4'd6, 3'd7);
      // row 7: SPACE SYMBOL(left Alt) M N B , . INV
      9'h029: m = km(4'd7, 3'd0);
      9'h011: m = km(4'd7, 3'd1);
      9'h03A: m = km(4'd7, 3'd2);
      9'h031: m = km(4'd7, 3'd3);
      9'h032: m = km(4'd7, 3'd4);
      9'h041: m = km(4'd7, 3'd5);
      9'h049: m = km(4'd7, 3'd6);
      9'h04A: m = km(4'd7, 3'd7);
      // row 8: CTRL UP DOWN LEFT RIGHT
      9'h014: m = km(4'd8, 3'd0);
      9'h175: m = km(4'd8, 3'd1);
      9'h172: m = km(4'd8, 3'd2);
      9'h16B: m = km(4'd8, 3'd3);
      9'h174: m = km(4'd8, 3'd4);
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sam_kbd_pulse.sv
// Counter-driven active-low pulse generator. A trigger while idle drives the
// output low for PULSE_LEN cycles; triggers during an active pulse are ignored.
module sam_kbd_pulse #(
  parameter logic [15:0] PULSE_LEN = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_trig,
  output logic o_pulse_n
);

  logic [15:0] r_cnt;
  logic        r_pulse_n;

  // Load on an idle trigger, then count down; output is low while count != 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 16'd0;
      r_pulse_n <= 1'b1;
    end else if (i_trig && (r_cnt == 16'd0)) begin
      r_cnt     <= PULSE_LEN;
      r_pulse_n <= 1'b0;
    end else if (r_cnt != 16'd0) begin
      r_cnt     <= r_cnt - 16'd1;
      r_pulse_n <= (r_cnt == 16'd1);
    end else begin
      r_cnt     <= 16'd0;
      r_pulse_n <= 1'b1;
    end
  end

  assign o_pulse_n = r_pulse_n;

endmodule

// File: rtl/ps2_sam_matrix.sv
// PS/2 set-2 scancode decoder maintaining the SAM keyboard matrix image,
// answering active-low row-select reads and generating hotkey pulses.
module ps2_sam_matrix
  import sam_kbd_pkg::*;
#(
  parameter int          ROWS      = 9,
  parameter int          COLS      = 8,
  parameter logic [15:0] PULSE_LEN = 16'd50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            scan_valid,
  input  logic [7:0]      scan,
  input  logic [ROWS-1:0] mat_row,
  output logic [COLS-1:0] mat_col,
  output logic            user_reset_n,
  output logic            master_reset_n,
  output logic            user_nmi_n
);

  kbd_state_e                r_state;
  logic [3:0]                r_skip;
  logic [ROWS-1:0][COLS-1:0] r_matrix;
  logic                      r_ctrl;
  logic                      r_alt;

  logic                      w_ev;
  logic                      w_make;
  logic                      w_ext;
  logic [7:0]                w_map;
  logic                      w_hit;
  logic [3:0]                w_row;
  logic [2:0]                w_col;
  logic                      w_hk_user;
  logic                      w_hk_master;
  logic                      w_hk_nmi;
  logic                      w_master_clr;
  logic [COLS-1:0]           w_rows_or;

  // Classify the current byte as a make/break key event given the prefix state
  always_comb begin
    w_ev   = 1'b0;
    w_make = 1'b0;
    w_ext  = 1'b0;
    if (scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if ((scan != SC_EXT) && (scan != SC_REL) && (scan != SC_PAUSE) && !is_ignored(scan)) begin
            w_ev   = 1'b1;
            w_make = 1'b1;
          end else begin
            w_ev   = 1'b0;
          end
        end
        ST_EXT: begin
          if ((scan != SC_REL) && (scan != SC_LSHIFT) && (scan != SC_RSHIFT)) begin
            w_ev   = 1'b1;
            w_make = 1'b1;
            w_ext  = 1'b1;
          end else begin
            w_ev   = 1'b0;
          end
        end
        ST_REL: begin
          w_ev = 1'b1;
        end
        ST_EXT_REL: begin
          w_ev  = 1'b1;
          w_ext = 1'b1;
        end
        default: begin
          w_ev = 1'b0;
        end
      endcase
    end else begin
      w_ev = 1'b0;
    end
  end

  assign w_map = sam_keymap(w_ext, scan);
  assign w_hit = w_map[7];
  assign w_row = w_map[6:3];
  assign w_col = w_map[2:0];

  // Hotkeys use the modifier state from before this byte
  assign w_hk_user    = w_ev & w_make &  w_ext & (scan == SC_DEL)  & r_ctrl & r_alt;
  assign w_hk_master  = w_ev & w_make & ~w_ext & (scan == SC_BKSP) & r_ctrl & r_alt;
  assign w_hk_nmi     = w_ev & w_make & ~w_ext & (scan == SC_F11);
  // Clear only when the master pulse actually starts (output idle-high now)
  assign w_master_clr = w_hk_master & master_reset_n;

  // Prefix FSM: tracks E0/F0 prefixes and swallows the E1 Pause sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_skip  <= 4'd0;
    end else if (scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (scan == SC_EXT) begin
            r_state <= ST_EXT;
          end else if (scan == SC_REL) begin
            r_state <= ST_REL;
          end else if (scan == SC_PAUSE) begin
            r_state <= ST_PAUSE;
            r_skip  <= PAUSE_SKIP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXT: begin
          if (scan == SC_REL) begin
            r_state <= ST_EXT_REL;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REL, ST_EXT_REL: begin
          r_state <= ST_IDLE;
        end
        ST_PAUSE: begin
          r_skip <= r_skip - 4'd1;
          if (r_skip <= 4'd1) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_PAUSE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end else begin
      r_state <= r_state;
    end
  end

  // Matrix image: make sets, break clears, master hotkey wipes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_matrix <= '0;
    end else if (w_master_clr) begin
      r_matrix <= '0;
    end else if (w_ev && w_hit) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if ((r == int'(w_row)) && (c == int'(w_col))) begin
            r_matrix[r][c] <= w_make;
          end
        end
      end
    end else begin
      r_matrix <= r_matrix;
    end
  end

  // Modifier trackers for hotkey qualification (either Ctrl, either Alt)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= 1'b0;
      r_alt  <= 1'b0;
    end else if (w_master_clr) begin
      r_ctrl <= 1'b0;
      r_alt  <= 1'b0;
    end else if (w_ev) begin
      if (scan == SC_CTRL) begin
        r_ctrl <= w_make;
      end else if (scan == SC_ALT) begin
        r_alt <= w_make;
      end else begin
        r_ctrl <= r_ctrl;
      end
    end else begin
      r_ctrl <= r_ctrl;
      r_alt  <= r_alt;
    end
  end

  // Column readback: OR of every selected (low) row, inverted
  always_comb begin
    w_rows_or = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!mat_row[r]) begin
        w_rows_or = w_rows_or | r_matrix[r];
      end else begin
        w_rows_or = w_rows_or;
      end
    end
  end

  assign mat_col = ~w_rows_or;

  sam_kbd_pulse #(.PULSE_LEN(PULSE_LEN)) u_user_pulse (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_trig    (w_hk_user),
    .o_pulse_n (user_reset_n)
  );

  sam_kbd_pulse #(.PULSE_LEN(PULSE_LEN)) u_master_pulse (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_trig    (w_hk_master),
    .o_pulse_n (master_reset_n)
  );

  sam_kbd_pulse #(.PULSE_LEN(PULSE_LEN)) u_nmi_pulse (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_trig    (w_hk_nmi),
    .o_pulse_n (user_nmi_n)
  );

endmodule

// File: tb/tb_ps2_sam_matrix.sv
// Directed testbench for ps2_sam_matrix with PULSE_LEN = 4.
module tb_ps2_sam_matrix;

  logic       clk;
  logic       rst_n;
  logic       scan_valid;
  logic [7:0] scan;
  logic [8:0] mat_row;
  logic [7:0] mat_col;
  logic       user_reset_n;
  logic       master_reset_n;
  logic       user_nmi_n;

  int checks;
  int failures;

  ps2_sam_matrix #(.ROWS(9), .COLS(8), .PULSE_LEN(16'd4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .scan_valid     (scan_valid),
    .scan           (scan),
    .mat_row        (mat_row),
    .mat_col        (mat_col),
    .user_reset_n   (user_reset_n),
    .master_reset_n (master_reset_n),
    .user_nmi_n     (user_nmi_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; presents one byte for one cycle, returns at next negedge
  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scan       = b;
    @(negedge clk);
    scan_valid = 1'b0;
    scan       = 8'h00;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    scan_valid = 1'b0;
    scan       = 8'h00;
    mat_row    = 9'h1FE;
    repeat (2) @(negedge clk);
    chk("rst_col",    {8'h00, mat_col}, 16'h00FF);
    chk("rst_user",   {15'd0, user_reset_n}, 16'h0001);
    chk("rst_master", {15'd0, master_reset_n}, 16'h0001);
    chk("rst_nmi",    {15'd0, user_nmi_n}, 16'h0001);
    rst_n = 1'b1;
    @(negedge clk);

    // Z make/break on row 0
    send(8'h1A);
    chk("z_make", {8'h00, mat_col}, 16'h00FD);
    send(8'h1A);
    chk("z_typematic", {8'h00, mat_col}, 16'h00FD);
    send(8'hF0); send(8'h1A);
    chk("z_break", {8'h00, mat_col}, 16'h00FF);
    send(8'hF0); send(8'h1A);
    chk("z_break_again", {8'h00, mat_col}, 16'h00FF);

    // Extended UP on row 8, then bare 75 on row 4
    mat_row = 9'h0FF;
    send(8'hE0); send(8'h75);
    chk("up_make", {8'h00, mat_col}, 16'h00FD);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_break", {8'h00, mat_col}, 16'h00FF);
    send(8'h75);
    chk("kp8_row8", {8'h00, mat_col}, 16'h00FF);
    mat_row = 9'h1EF;
    #1;
    chk("kp8_row4", {8'h00, mat_col}, 16'h00BF);
    send(8'hF0); send(8'h75);
    chk("kp8_break", {8'h00, mat_col}, 16'h00FF);

    // Fake shift after E0 is ignored
    mat_row = 9'h1FE;
    send(8'hE0); send(8'h12);
    chk("fake_shift", {8'h00, mat_col}, 16'h00FF);

    // Pause sequence swallowed, then A decodes fresh
    mat_row = 9'h000;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_nochange", {8'h00, mat_col}, 16'h00FF);
    send(8'h1C);
    mat_row = 9'h1FD;
    #1;
    chk("after_pause_a", {8'h00, mat_col}, 16'h00FE);
    send(8'hF0); send(8'h1C);

    // Ctrl+Alt+Del: 4-cycle user reset, retrigger mid-pulse ignored
    send(8'h14); send(8'h11); send(8'hE0);
    chk("user_pre", {15'd0, user_reset_n}, 16'h0001);
    send(8'h71);
    chk("user_low1", {15'd0, user_reset_n}, 16'h0000);
    mat_row = 9'h1EF;
    #1;
    chk("del_in_matrix", {8'h00, mat_col}, 16'h007F);
    send(8'hE0);
    chk("user_low2", {15'd0, user_reset_n}, 16'h0000);
    send(8'h71);
    chk("user_low3", {15'd0, user_reset_n}, 16'h0000);
    @(negedge clk);
    chk("user_low4", {15'd0, user_reset_n}, 16'h0000);
    @(negedge clk);
    chk("user_high_end", {15'd0, user_reset_n}, 16'h0001);
    @(negedge clk);
    chk("user_no_extend", {15'd0, user_reset_n}, 16'h0001);
    chk("user_master_idle", {15'd0, master_reset_n}, 16'h0001);
    send(8'hE0); send(8'hF0); send(8'h71);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h11);
    mat_row = 9'h000;
    #1;
    chk("all_released", {8'h00, mat_col}, 16'h00FF);

    // Master hotkey with Z and A held clears matrix and modifiers
    send(8'h1A); send(8'h1C); send(8'h14); send(8'h11);
    chk("held_keys", {8'h00, mat_col}, 16'h00FC);
    send(8'h66);
    chk("master_low1", {15'd0, master_reset_n}, 16'h0000);
    chk("master_clear", {8'h00, mat_col}, 16'h00FF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("master_low", {15'd0, master_reset_n}, 16'h0000);
    end
    @(negedge clk);
    chk("master_high_end", {15'd0, master_reset_n}, 16'h0001);
    send(8'hE0); send(8'h71);
    chk("mods_cleared", {15'd0, user_reset_n}, 16'h0001);
    send(8'hE0); send(8'hF0); send(8'h71);

    // F11 NMI pulse
    send(8'h78);
    chk("nmi_low1", {15'd0, user_nmi_n}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nmi_low", {15'd0, user_nmi_n}, 16'h0000);
    end
    @(negedge clk);
    chk("nmi_high_end", {15'd0, user_nmi_n}, 16'h0001);
    send(8'hF0); send(8'h78);

    // Controller bytes ignored; FSM stays IDLE so Z decodes as make
    send(8'hAA); send(8'hFA); send(8'h00);
    chk("ignored_matrix", {8'h00, mat_col}, 16'h00FF);
    chk("ignored_outs", {13'd0, user_reset_n, master_reset_n, user_nmi_n}, 16'h0007);
    send(8'h1A);
    mat_row = 9'h1FE;
    #1;
    chk("ignored_then_z", {8'h00, mat_col}, 16'h00FD);
    send(8'hF0); send(8'h1A);

    // Reset after E0: next 75 is keypad 8 on row 4, not UP
    send(8'hE0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h75);
    mat_row = 9'h1EF;
    #1;
    chk("rst_mid_row4", {8'h00, mat_col}, 16'h00BF);
    mat_row = 9'h0FF;
    #1;
    chk("rst_mid_row8", {8'h00, mat_col}, 16'h00FF);
    mat_row = 9'h1FF;
    #1;
    chk("no_row_sel", {8'h00, mat_col}, 16'h00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_sam_matrix.md
# ps2_sam_matrix

Synchronous, parametrised PS/2 set-2 scancode decoder that maintains a keyboard matrix image and answers row-select reads from the ASIC keyboard port. Sits between the PS/2 receiver, which supplies a one-cycle `scan_valid` strobe per byte, and the SAM ASIC port logic. It adds three things:
- full prefix handling (E0, F0, the E1 Pause sequence and controller bytes);
- hotkey detection driving timed, active-low reset and NMI pulses;
- matrix clearing on master reset.

## Interface
Parameters:
- `ROWS`, 9, number of matrix rows (minimum 9 for the SAM keymap).
- `COLS`, 8, number of matrix columns (minimum 8).
- `PULSE_LEN`, 16'd50000, width of each hotkey output pulse in `clk` cycles. Legal range 1..65535.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `scan_valid`  in  1  one-cycle strobe; `scan` is valid while it is high.
- `scan`  in  8  received PS/2 byte.
- `mat_row`  in  ROWS  active-low row select; more than one row may be low at once.
- `mat_col`  out  COLS  active-low column readback.
- `user_reset_n`  out  1  active-low user reset pulse.
- `master_reset_n`  out  1  active-low master reset pulse.
- `user_nmi_n`  out  1  active-low NMI pulse.

## Operation
- Matrix: `ROWS×COLS` register bits, 1 = pressed.
- `mat_col` = NOT(OR of all rows whose `mat_row` bit is 0).
- `mat_col` is purely combinational from the registered matrix and `mat_row`.
- Prefix FSM states: `IDLE`, `EXT`, `REL`, `EXT_REL`, `PAUSE`. It advances only on `scan_valid`.
  - `IDLE`: E0→`EXT`; F0→`REL`; E1→`PAUSE` with skip count 7.
  - `IDLE`: 00, AA, EE, FA, FE, FF are ignored and the state stays `IDLE`.
  - `IDLE`: any other byte is a make code (ext=0), then stay in `IDLE`.
  - `EXT`: F0→`EXT_REL`; 12 or 59 (fake shifts) are ignored →`IDLE`; any other byte is a make (ext=1) →`IDLE`.
  - `REL`: any byte is a break (ext=0) →`IDLE`.
  - `EXT_REL`: any byte is a break (ext=1) →`IDLE`.
  - `PAUSE`: each byte decrements the skip count; at 0 →`IDLE`. No matrix change and no hotkey.
- Make sets the mapped matrix bit; break clears it. Unmapped codes are ignored.
- Repeated makes (typematic) are idempotent. A break for a key that is not pressed is a no-op.
- Both shift keys (12, 59) map to CS. The keymap is fixed to the SAM 9×8 layout:
  - rows 0..7 are the alphanumeric, function and edit keys;
  - row 8 is CTRL(14), UP(E075), DN(E072), LT(E06B), RT(E074);
  - EDIT is E011 (right Alt). Left Alt (11) is SYMBOL.
- Modifier trackers, separate from the matrix: `ctrl` (14 or E014) and `alt` (11 or E011). Both are updated on make and break.
- Hotkeys fire on the make only, evaluated with the modifier state as it was before this byte:
  - Ctrl+Alt+Del(E071) → `user_reset_n`.
  - Ctrl+Alt+Backspace(66) → `master_reset_n`.
  - F11(78), no modifiers needed → `user_nmi_n`.
  - The key's own matrix update still occurs.
- Pulses: each output has its own counter. A trigger loads `PULSE_LEN` and drives the output low until the counter reaches 0. A trigger while the pulse is already active is ignored (no retrigger).
- Master hotkey: also clears the entire matrix and both modifiers on the same cycle the pulse starts. This overrides the Backspace make update.

## Timing
- Reset values:
  - all matrix bits 0, so `mat_col` = all 1s for any `mat_row`;
  - FSM `IDLE`, modifiers 0, counters 0;
  - `user_reset_n`, `master_reset_n` and `user_nmi_n` all 1.
- `scan_valid` at cycle N → matrix, modifiers and FSM updated at edge N+1. `mat_col` reflects the change in cycle N+1.
- Hotkey make at cycle N → output low from N+1 through N+`PULSE_LEN`, high again at N+`PULSE_LEN`+1.
- Back-to-back `scan_valid` on consecutive cycles is supported: one byte per cycle, no stall.
- `rst_n` low mid-sequence (e.g. after E0 or within `PAUSE`) returns the FSM to `IDLE` immediately. The next byte is decoded fresh.
- `mat_row` all 1s → `mat_col` all 1s.

## Structure
- Package `sam_kbd_pkg`:
  - scancode constants (prefixes E0/F0/E1, ignored codes, modifier and hotkey codes);
  - FSM state enum;
  - `PAUSE_SKIP`=7;
  - keymap function `{ext, code} → {hit, row[3:0], col[2:0]}`.
- Sub-module `sam_kbd_pulse`: one counter-driven active-low pulse generator, `PULSE_LEN` parameter. It is instantiated three times.

## Test plan
- Reset, then `mat_row`=9'h1FE → `mat_col`=8'hFF. Send 1A → `mat_col`=8'hFD. Send F0,1A → `mat_col`=8'hFF.
- E0,75 with `mat_row`=9'h0FF → `mat_col`=8'hFD. E0,F0,75 → 8'hFF. A bare 75 sets row 4 bit 6 instead.
- E1,14,77,E1,F0,14,F0,77 → matrix unchanged, FSM `IDLE`. A following 1C sets row 1 bit 0.
- With `PULSE_LEN`=4: 14,11,E0,71 → `user_reset_n` low exactly 4 cycles starting the cycle after 71. A repeat E0,71 mid-pulse does not extend it.
- Hold 1A and 1C, then send 14,11,66 → `master_reset_n` low for `PULSE_LEN` cycles. The matrix reads all released in the next cycle.
- 78 → `user_nmi_n` pulse. AA, FA and 00 alone → no matrix, FSM or output change. Assert `rst_n` low after E0, then send 75 → row 4 bit 6 set (not UP).
